mips_muldiv_unit: RTL and testbench

- Parametrised, multi-cycle HI/LO arithmetic unit for the MIPS datapath. It sits beside the single-cycle ALU in the execute stage.
- Executes R-type funct codes MULT, MULTU, DIV, DIVU iteratively, one bit per clock, plus MFHI, MFLO, MTHI, MTLO.
- Owns the architectural HI/LO registers and exposes a start/busy/done handshake so the pipeline can stall while an operation is in flight.

---
 rtl/mips_muldiv_unit_if.sv | 25 ++
 rtl/mips_muldiv_unit.sv | 188 ++++++++++++++++++
 tb/tb_mips_muldiv_unit.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_muldiv_unit_if.sv
// Request/response bundle between the execute stage and the HI/LO multiply/divide unit.
interface mips_muldiv_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [5:0]       funct;
  logic [WIDTH-1:0] rs_value;
  logic [WIDTH-1:0] rt_value;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_by_zero;

  modport master (
    output start, funct, rs_value, rt_value,
    input  busy, done, result, hi, lo, div_by_zero
  );

  modport slave (
    input  start, funct, rs_value, rt_value,
    output busy, done, result, hi, lo, div_by_zero
  );
endinterface

// File: rtl/mips_muldiv_unit.sv
// Iterative MIPS HI/LO unit: shift-add multiply and restoring divide, one bit per clock,
// plus the single-cycle MFHI/MFLO/MTHI/MTLO moves.
module mips_muldiv_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input logic              clk,
  input logic              reset_n,
  mips_muldiv_unit_if.slave bus
);

  localparam logic [5:0] FnMfhi  = 6'h10;
  localparam logic [5:0] FnMthi  = 6'h11;
  localparam logic [5:0] FnMflo  = 6'h12;
  localparam logic [5:0] FnMtlo  = 6'h13;
  localparam logic [5:0] FnMult  = 6'h18;
  localparam logic [5:0] FnMultu = 6'h19;
  localparam logic [5:0] FnDiv   = 6'h1A;
  localparam logic [5:0] FnDivu  = 6'h1B;

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StFix} state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  // Multiply: {partial product, remaining multiplier}. Divide: {remainder, dividend/quotient}.
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     opb_q, opb_d;       // multiplicand or divisor
  logic                 sign_q, sign_d;     // negate product / quotient
  logic                 sign_r_q, sign_r_d; // negate remainder
  logic                 div_q, div_d;
  logic                 zero_q, zero_d;     // divisor was zero
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic                 done_q, done_d;
  logic                 dbz_q, dbz_d;

  logic                 is_signed;
  logic [WIDTH-1:0]     a_op, b_op;
  logic [WIDTH:0]       mul_sum, rem_shift, rem_sub;
  logic [2*WIDTH-1:0]   prod;

  // Next-state, datapath iteration and result write-back.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opb_d     = opb_q;
    sign_d    = sign_q;
    sign_r_d  = sign_r_q;
    div_d     = div_q;
    zero_d    = zero_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    result_d  = result_q;
    done_d    = 1'b0;
    dbz_d     = dbz_q;
    is_signed = (bus.funct == FnMult) || (bus.funct == FnDiv);
    a_op      = (is_signed && bus.rs_value[WIDTH-1]) ? -bus.rs_value : bus.rs_value;
    b_op      = (is_signed && bus.rt_value[WIDTH-1]) ? -bus.rt_value : bus.rt_value;
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    rem_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    rem_sub   = rem_shift - {1'b0, opb_q};
    prod      = sign_q ? -acc_q : acc_q;

    case (state_q)
      StIdle: begin
        if (bus.start) begin
          case (bus.funct)
            FnMult, FnMultu: begin
              acc_d    = {{WIDTH{1'b0}}, b_op};
              opb_d    = a_op;
              sign_d   = is_signed & (bus.rs_value[WIDTH-1] ^ bus.rt_value[WIDTH-1]);
              sign_r_d = 1'b0;
              div_d    = 1'b0;
              zero_d   = 1'b0;
              cnt_d    = '0;
              state_d  = StMul;
            end
            FnDiv, FnDivu: begin
              acc_d    = {{WIDTH{1'b0}}, a_op};
              opb_d    = b_op;
              sign_d   = is_signed & (bus.rs_value[WIDTH-1] ^ bus.rt_value[WIDTH-1]);
              sign_r_d = is_signed & bus.rs_value[WIDTH-1];
              div_d    = 1'b1;
              zero_d   = (bus.rt_value == '0);
              cnt_d    = '0;
              state_d  = StDiv;
            end
            FnMthi: begin
              hi_d   = bus.rs_value;
              done_d = 1'b1;
              dbz_d  = 1'b0;
            end
            FnMtlo: begin
              lo_d   = bus.rs_value;
              done_d = 1'b1;
              dbz_d  = 1'b0;
            end
            FnMfhi: begin
              result_d = hi_q;
              done_d   = 1'b1;
              dbz_d    = 1'b0;
            end
            FnMflo: begin
              result_d = lo_q;
              done_d   = 1'b1;
              dbz_d    = 1'b0;
            end
            default: ;
          endcase
        end
      end
      StMul: begin
        acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = StFix;
      end
      StDiv: begin
        // A clear borrow bit means the shifted remainder covers the divisor.
        if (!rem_sub[WIDTH]) begin
          acc_d = {rem_sub[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = {rem_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = StFix;
      end
      StFix: begin
        if (div_q) begin
          // With a zero divisor every step subtracts nothing, so the remainder ends up as |A|;
          // the remainder sign fix then restores rs_value exactly.
          lo_d  = zero_q ? '1 : (sign_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
          hi_d  = sign_r_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
          dbz_d = zero_q;
        end else begin
          hi_d  = prod[2*WIDTH-1:WIDTH];
          lo_d  = prod[WIDTH-1:0];
          dbz_d = 1'b0;
        end
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and architectural registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      sign_q   <= 1'b0;
      sign_r_q <= 1'b0;
      div_q    <= 1'b0;
      zero_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      sign_q   <= sign_d;
      sign_r_q <= sign_r_d;
      div_q    <= div_d;
      zero_q   <= zero_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      result_q <= result_d;
      done_q   <= done_d;
      dbz_q    <= dbz_d;
    end
  end

  assign bus.busy        = (state_q != StIdle);
  assign bus.done        = done_q;
  assign bus.result      = result_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Randomised self-checking bench for mips_muldiv_unit against an arithmetic HI/LO model.
module tb_mips_muldiv_unit;
  localparam int unsigned W = 32;

  localparam logic [5:0] FnMfhi  = 6'h10;
  localparam logic [5:0] FnMthi  = 6'h11;
  localparam logic [5:0] FnMflo  = 6'h12;
  localparam logic [5:0] FnMtlo  = 6'h13;
  localparam logic [5:0] FnMult  = 6'h18;
  localparam logic [5:0] FnMultu = 6'h19;
  localparam logic [5:0] FnDiv   = 6'h1A;
  localparam logic [5:0] FnDivu  = 6'h1B;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  mips_muldiv_unit_if #(.WIDTH(W)) bus_if ();

  mips_muldiv_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_if)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference architectural state.
  logic [W-1:0] hi_m, lo_m, res_m;
  logic         dbz_m;

  logic [5:0] fns [8] = '{FnMfhi, FnMthi, FnMflo, FnMtlo, FnMult, FnMultu, FnDiv, FnDivu};

  task automatic check_eq(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic model_apply(input logic [5:0] fn, input logic [W-1:0] a, input logic [W-1:0] b);
    longint      sp;
    logic [63:0] up;
    int          sa, sb;
    sa = a;
    sb = b;
    case (fn)
      FnMult: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        {hi_m, lo_m} = sp;
        dbz_m = 1'b0;
      end
      FnMultu: begin
        up = {32'd0, a} * {32'd0, b};
        {hi_m, lo_m} = up;
        dbz_m = 1'b0;
      end
      FnDiv: begin
        if (b == 0) begin
          lo_m = '1; hi_m = a; dbz_m = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          lo_m = 32'h8000_0000; hi_m = '0; dbz_m = 1'b0;
        end else begin
          lo_m = sa / sb; hi_m = sa % sb; dbz_m = 1'b0;
        end
      end
      FnDivu: begin
        if (b == 0) begin
          lo_m = '1; hi_m = a; dbz_m = 1'b1;
        end else begin
          lo_m = a / b; hi_m = a % b; dbz_m = 1'b0;
        end
      end
      FnMthi: begin hi_m = a;     dbz_m = 1'b0; end
      FnMtlo: begin lo_m = a;     dbz_m = 1'b0; end
      FnMfhi: begin res_m = hi_m; dbz_m = 1'b0; end
      FnMflo: begin res_m = lo_m; dbz_m = 1'b0; end
      default: ;
    endcase
  endtask

  // Issue one operation (entered #1 after an edge) and return in the cycle where done is high.
  // With poke set, an MTHI is thrown at the unit while it is busy and must be ignored.
  task automatic run_op(input string tag, input logic [5:0] fn, input logic [W-1:0] a,
                        input logic [W-1:0] b, input bit poke);
    int           lat;
    bit           busy_ok, hilo_ok, multi;
    logic [W-1:0] hi_prev, lo_prev;
    multi   = fn[3];
    hi_prev = hi_m;
    lo_prev = lo_m;
    bus_if.start    = 1'b1;
    bus_if.funct    = fn;
    bus_if.rs_value = a;
    bus_if.rt_value = b;
    @(posedge clk); #1;
    bus_if.start = 1'b0;
    model_apply(fn, a, b);
    lat = 0;
    busy_ok = 1'b1;
    hilo_ok = 1'b1;
    while (bus_if.done !== 1'b1 && lat < 100) begin
      if (bus_if.busy !== 1'b1) busy_ok = 1'b0;
      if (bus_if.hi !== hi_prev || bus_if.lo !== lo_prev) hilo_ok = 1'b0;
      if (poke && lat == 4) begin
        bus_if.start    = 1'b1;
        bus_if.funct    = FnMthi;
        bus_if.rs_value = $urandom;
      end else begin
        bus_if.start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    bus_if.start = 1'b0;
    check_eq({tag, " latency"}, lat, multi ? W + 1 : 0);
    if (multi) begin
      check_eq({tag, " busy_held"}, busy_ok, 1'b1);
      check_eq({tag, " hilo_stable"}, hilo_ok, 1'b1);
    end
    check_eq({tag, " busy_at_done"}, bus_if.busy, 1'b0);
    check_eq({tag, " hi"}, bus_if.hi, hi_m);
    check_eq({tag, " lo"}, bus_if.lo, lo_m);
    check_eq({tag, " result"}, bus_if.result, res_m);
    check_eq({tag, " dbz"}, bus_if.div_by_zero, dbz_m);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, " busy"}, bus_if.busy, 1'b0);
    check_eq({tag, " done"}, bus_if.done, 1'b0);
    check_eq({tag, " hi"}, bus_if.hi, '0);
    check_eq({tag, " lo"}, bus_if.lo, '0);
    check_eq({tag, " result"}, bus_if.result, '0);
    check_eq({tag, " dbz"}, bus_if.div_by_zero, 1'b0);
  endtask

  function automatic logic [W-1:0] pick_val();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    bus_if.start    = 1'b0;
    bus_if.funct    = '0;
    bus_if.rs_value = '0;
    bus_if.rt_value = '0;
    hi_m = '0; lo_m = '0; res_m = '0; dbz_m = 1'b0;

    #2;
    check_reset_outputs("por");
    #10 reset_n = 1'b1;
    @(posedge clk); #1;

    run_op("mult_neg3x5", FnMult, 32'hFFFF_FFFD, 32'd5, 1'b0);
    check_eq("mult_neg3x5 hi_const", bus_if.hi, 32'hFFFF_FFFF);
    check_eq("mult_neg3x5 lo_const", bus_if.lo, 32'hFFFF_FFF1);
    run_op("multu_max", FnMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    check_eq("multu_max hi_const", bus_if.hi, 32'hFFFF_FFFE);
    check_eq("multu_max lo_const", bus_if.lo, 32'h0000_0001);
    run_op("div_neg7by2", FnDiv, 32'hFFFF_FFF9, 32'd2, 1'b0);
    check_eq("div_neg7by2 lo_const", bus_if.lo, 32'hFFFF_FFFD);
    check_eq("div_neg7by2 hi_const", bus_if.hi, 32'hFFFF_FFFF);
    run_op("divu_by0", FnDivu, 32'd7, 32'd0, 1'b0);
    check_eq("divu_by0 lo_const", bus_if.lo, 32'hFFFF_FFFF);
    check_eq("divu_by0 hi_const", bus_if.hi, 32'd7);
    check_eq("divu_by0 dbz_const", bus_if.div_by_zero, 1'b1);
    @(posedge clk); #1;
    check_eq("done_falls", bus_if.done, 1'b0);

    run_op("mthi", FnMthi, 32'h1234_5678, $urandom, 1'b0);
    run_op("mfhi", FnMfhi, $urandom, $urandom, 1'b0);
    check_eq("mfhi result_const", bus_if.result, 32'h1234_5678);

    run_op("mult_poke", FnMult, $urandom, $urandom, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_eq($sformatf("single_done %0d", i), bus_if.done, 1'b0);
    end

    run_op("div_ovf", FnDiv, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    check_eq("div_ovf lo_const", bus_if.lo, 32'h8000_0000);
    check_eq("div_ovf hi_const", bus_if.hi, 32'd0);
    check_eq("div_ovf dbz_const", bus_if.div_by_zero, 1'b0);

    // Unlisted funct must be ignored.
    bus_if.start    = 1'b1;
    bus_if.funct    = 6'h20;
    bus_if.rs_value = $urandom;
    @(posedge clk); #1;
    bus_if.start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("bad_fn done %0d", i), bus_if.done, 1'b0);
      check_eq($sformatf("bad_fn busy %0d", i), bus_if.busy, 1'b0);
      @(posedge clk); #1;
    end
    check_eq("bad_fn hi", bus_if.hi, hi_m);
    check_eq("bad_fn lo", bus_if.lo, lo_m);

    // Random back-to-back traffic.
    for (int i = 0; i < 40; i++) begin
      logic [5:0] fn;
      fn = fns[$urandom_range(0, 7)];
      run_op($sformatf("rnd%0d_f%02h", i, fn), fn, pick_val(), pick_val(), 1'b0);
    end

    // Make HI/LO non-zero, then reset in the middle of a multiply, between clock edges.
    run_op("pre_rst_mthi", FnMthi, 32'hA5A5_0001, '0, 1'b0);
    run_op("pre_rst_mtlo", FnMtlo, 32'h5A5A_0002, '0, 1'b0);
    bus_if.start    = 1'b1;
    bus_if.funct    = FnMult;
    bus_if.rs_value = $urandom;
    bus_if.rt_value = $urandom;
    @(posedge clk); #1;
    bus_if.start = 1'b0;
    repeat (9) @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    hi_m = '0; lo_m = '0; res_m = '0; dbz_m = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    run_op("post_rst_mult", FnMult, $urandom, $urandom, 1'b0);
    run_op("post_rst_mflo", FnMflo, '0, '0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
